// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back/write-allocate cache with true-LRU; define ASSOC_CACHE_STATS_EN for hit/miss/write-back counters
module assoc_cache #(
   parameter int WIDTH       = 32,
   parameter int WAYS        = 4,
   parameter int SETS        = 64,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          cpu_addr,
   input  logic [31:0]               cpu_wdata,
   input  logic                      cpu_read,
   input  logic                      cpu_write,
   input  logic [1:0]                cpu_size,
   output logic [31:0]               read_data,
   output logic                      stall,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [WIDTH-1:0]          mem_addr,
   output logic [32*BLOCK_WORDS-1:0] mem_wdata,
   input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
   input  logic                      mem_ready
`ifdef ASSOC_CACHE_STATS_EN
   ,
   output logic [31:0]               hit_count,
   output logic [31:0]               miss_count,
   output logic [31:0]               wb_count
`endif
);
   localparam int WO_W  = BLOCK_WORDS > 1 ? $clog2(BLOCK_WORDS) : 1;
   localparam int OFF_W = 2 + $clog2(BLOCK_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = WIDTH - OFF_W - IDX_W;
   localparam int WAY_W = $clog2(WAYS);

   typedef enum logic [1:0] {IDLE, WRITE_BACK, REFILL} state_t;

   state_t             state_q, state_d;
   logic [WAY_W-1:0]   vic_q, vic_d;
   logic               valid_q [WAYS][SETS];
   logic               dirty_q [WAYS][SETS];
   logic [WAY_W-1:0]   age_q   [WAYS][SETS];
   logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
   logic [31:0]        data_q  [WAYS][SETS][BLOCK_WORDS];
   logic [WAY_W-1:0]   age_d   [WAYS];
   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic [WO_W-1:0]    wsel;
   logic [WAY_W-1:0]   hit_way, victim, lru_way;
   logic               req, hit, lru_we, refill_we, store_we;
   logic [31:0]        hit_word, wnew;

   assign idx       = cpu_addr[OFF_W +: IDX_W];
   assign tag       = cpu_addr[WIDTH-1 -: TAG_W];
   assign wsel      = WO_W'((cpu_addr >> 2) & WIDTH'(BLOCK_WORDS - 1));
   assign req       = cpu_read | cpu_write;
   assign hit_word  = data_q[hit_way][idx][wsel];
   assign read_data = (cpu_read && !cpu_write && hit) ? hit_word : 32'd0;
   assign stall     = (state_q != IDLE) | (req & ~hit);

   // tag match in the indexed set, and victim choice: lowest invalid way, else the oldest
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (age_q[w][idx] == WAY_W'(WAYS - 1))
            victim = WAY_W'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[w][idx])
            victim = WAY_W'(w);
   end

   // merge store data into the hit word; half ignores addr[0], word ignores addr[1:0]
   always_comb begin
      wnew = hit_word;
      for (int l = 0; l < 4; l++)
         if (cpu_size[1] || (cpu_size[0] && cpu_addr[1] == l[1]) || (cpu_size == 2'b00 && cpu_addr[1:0] == l[1:0]))
            wnew[8*l +: 8] = cpu_wdata[8*(cpu_size[1] ? l : cpu_size[0] ? l % 2 : 0) +: 8];
   end

   // true-LRU ages after touching lru_way: it becomes 0, younger ways age by one
   always_comb
      for (int w = 0; w < WAYS; w++)
         age_d[w] = (WAY_W'(w) == lru_way) ? '0 :
                    (age_q[w][idx] < age_q[lru_way][idx]) ? age_q[w][idx] + 1'b1 : age_q[w][idx];

   // miss FSM next state, memory port drive and array write strobes
   always_comb begin
      state_d   = state_q;
      vic_d     = vic_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      store_we  = 1'b0;
      refill_we = 1'b0;
      lru_we    = 1'b0;
      lru_way   = hit_way;
      case (state_q)
         IDLE:
            if (req && hit) begin
               lru_we   = 1'b1;
               store_we = cpu_write;
            end else if (req) begin
               vic_d   = victim;
               state_d = (valid_q[victim][idx] && dirty_q[victim][idx]) ? WRITE_BACK : REFILL;
            end
         WRITE_BACK: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {tag_q[vic_q][idx], idx, OFF_W'(0)};
            for (int k = 0; k < BLOCK_WORDS; k++)
               mem_wdata[32*k +: 32] = data_q[vic_q][idx][k];
            if (mem_ready)
               state_d = REFILL;
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag, idx, OFF_W'(0)};
            if (mem_ready) begin
               refill_we = 1'b1;
               lru_we    = 1'b1;
               lru_way   = vic_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and line metadata; reset invalidates everything and abandons any transaction
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         vic_q   <= '0;
         for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
               age_q[w][s]   <= WAY_W'(w);
            end
      end else begin
         state_q <= state_d;
         vic_q   <= vic_d;
         if (refill_we) begin
            valid_q[vic_q][idx] <= 1'b1;
            dirty_q[vic_q][idx] <= 1'b0;
         end
         if (store_we)
            dirty_q[hit_way][idx] <= 1'b1;
         if (lru_we)
            for (int w = 0; w < WAYS; w++)
               age_q[w][idx] <= age_d[w];
      end

   // tag and data storage, qualified by valid so left unreset
   always_ff @(posedge clk)
      if (refill_we) begin
         tag_q[vic_q][idx] <= tag;
         for (int k = 0; k < BLOCK_WORDS; k++)
            data_q[vic_q][idx][k] <= mem_rdata[32*k +: 32];
      end else if (store_we)
         data_q[hit_way][idx][wsel] <= wnew;

`ifdef ASSOC_CACHE_STATS_EN
   // saturating event counters, cleared together with the cache
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (state_q == IDLE && req && hit && hit_count != '1)
            hit_count <= hit_count + 1'b1;
         if (state_q == IDLE && req && !hit && miss_count != '1)
            miss_count <= miss_count + 1'b1;
         if (state_q == WRITE_BACK && mem_ready && wb_count != '1)
            wb_count <= wb_count + 1'b1;
      end
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed test of assoc_cache against a recency-list cache model and a latency-programmable memory
module tb_assoc_cache;
   logic         clk = 1'b0, rst = 1'b1;
   logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
   logic         cpu_read = 1'b0, cpu_write = 1'b0;
   logic [1:0]   cpu_size = 2'b10;
   logic [31:0]  read_data, mem_addr;
   logic         stall, mem_req, mem_we;
   logic [127:0] mem_wdata, mem_rdata = '0;
   logic         mem_ready = 1'b0;
`ifdef ASSOC_CACHE_STATS_EN
   logic [31:0]  hit_count, miss_count, wb_count;
`endif
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   assoc_cache dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_size(cpu_size),
      .read_data(read_data), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef ASSOC_CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // backing memory: explicit lines, else an address-derived pattern
   logic [127:0] mem [int unsigned];
   int lat = 3, mcnt = 0;

   function automatic logic [127:0] line_of(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {32'h5A000000 | (a + 32'd12), 32'h5A000000 | (a + 32'd8), 32'h5A000000 | (a + 32'd4), 32'h5A000000 | a};
   endfunction

   initial forever begin
      @(posedge clk);
      #2;
      mem_ready = 1'b0;
      if (!mem_req) mcnt = 0;
      else begin
         mcnt++;
         if (mcnt >= lat) begin
            mcnt = 0;
            mem_ready = 1'b1;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = line_of(mem_addr);
         end
      end
   end

   // model: per-set recency list of ways (position 0 = most recent) plus line contents
   logic        mv [4][64];
   logic        md [4][64];
   logic [21:0] mt [4][64];
   logic [31:0] mdat [4][64][4];
   int          rk [64][4];
   int          mst = 0, mvic = 0;
   int          m_hits = 0, m_miss = 0, m_wb = 0;

   task automatic model_reset();
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 4; w++) begin
            mv[w][s] = 1'b0;
            md[w][s] = 1'b0;
            rk[s][w] = w;
         end
      mst = 0;
      m_hits = 0;
      m_miss = 0;
      m_wb = 0;
   endtask

   task automatic touch(input int s, input int w);
      int p = 0;
      for (int i = 0; i < 4; i++) if (rk[s][i] == w) p = i;
      for (int i = p; i > 0; i--) rk[s][i] = rk[s][i-1];
      rk[s][0] = w;
   endtask

   function automatic int pick(input int s);
      for (int w = 0; w < 4; w++) if (!mv[w][s]) return w;
      return rk[s][3];
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [1:0] sz, input logic [1:0] lo);
      logic [31:0] mask, val;
      if (sz == 2'b00) begin
         mask = 32'hFF << (8 * lo);
         val  = wd << (8 * lo);
      end else if (sz == 2'b01) begin
         mask = 32'hFFFF << (16 * lo[1]);
         val  = wd << (16 * lo[1]);
      end else begin
         mask = '1;
         val  = wd;
      end
      return (old & ~mask) | (val & mask);
   endfunction

   task automatic model_cycle();
      logic [31:0]  a = cpu_addr;
      int           s = int'((a >> 4) & 32'd63);
      int           wo = int'((a >> 2) & 32'd3);
      logic [21:0]  t = a[31:10];
      logic         rq = cpu_read | cpu_write;
      int           hw = -1;
      logic [31:0]  exp_rd = '0;
      if (rst) model_reset();
      for (int w = 0; w < 4; w++) if (mv[w][s] && mt[w][s] == t) hw = w;
      if (cpu_read && !cpu_write && hw >= 0) exp_rd = mdat[hw][s][wo];
      chk("stall", 128'(stall), 128'((mst != 0) || (rq && hw < 0)));
      chk("read_data", 128'(read_data), 128'(exp_rd));
      chk("mem_req", 128'(mem_req), 128'(mst != 0));
      if (mst != 0) begin
         chk("mem_we", 128'(mem_we), 128'(mst == 1));
         chk("mem_addr", 128'(mem_addr), 128'(mst == 1 ? ((32'(mt[mvic][s]) << 10) | (a & 32'h3F0)) : (a & 32'hFFFFFFF0)));
      end
      if (mst == 1)
         chk("mem_wdata", mem_wdata, {mdat[mvic][s][3], mdat[mvic][s][2], mdat[mvic][s][1], mdat[mvic][s][0]});
      if (rst) begin
         chk("rst_mem_addr", 128'(mem_addr), 128'(0));
         chk("rst_mem_wdata", mem_wdata, 128'(0));
         chk("rst_mem_we", 128'(mem_we), 128'(0));
      end
`ifdef ASSOC_CACHE_STATS_EN
      chk("hit_count", 128'(hit_count), 128'(m_hits));
      chk("miss_count", 128'(miss_count), 128'(m_miss));
      chk("wb_count", 128'(wb_count), 128'(m_wb));
`endif
      if (rst) return;
      if (mst == 0) begin
         if (rq && hw >= 0) begin
            touch(s, hw);
            m_hits++;
            if (cpu_write) begin
               mdat[hw][s][wo] = merge(mdat[hw][s][wo], cpu_wdata, cpu_size, a[1:0]);
               md[hw][s] = 1'b1;
            end
         end else if (rq) begin
            mvic = pick(s);
            m_miss++;
            mst = (mv[mvic][s] && md[mvic][s]) ? 1 : 2;
         end
      end else if (mst == 1) begin
         if (mem_ready) begin
            m_wb++;
            mst = 2;
         end
      end else if (mem_ready) begin
         mv[mvic][s] = 1'b1;
         md[mvic][s] = 1'b0;
         mt[mvic][s] = t;
         for (int k = 0; k < 4; k++) mdat[mvic][s][k] = mem_rdata[32*k +: 32];
         touch(s, mvic);
         mst = 0;
      end
   endtask

   always @(negedge clk) model_cycle();

   // per-access observations
   int          stalls;
   logic        saw_wb, saw_rf, timed_out;
   logic [31:0] wb_addr, wb_w0, rf_addr, rdata;

   task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk);
      #1;
      cpu_read = !wr;
      cpu_write = wr;
      cpu_size = sz;
      cpu_addr = a;
      cpu_wdata = wd;
      stalls = 0;
      saw_wb = 1'b0;
      saw_rf = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_req && mem_we) begin
            saw_wb = 1'b1;
            wb_addr = mem_addr;
            wb_w0 = mem_wdata[31:0];
         end
         if (mem_req && !mem_we) begin
            saw_rf = 1'b1;
            rf_addr = mem_addr;
         end
         if (!stall) begin
            timed_out = 1'b0;
            break;
         end
         stalls++;
      end
      chk("no_timeout", 128'(timed_out), 128'(0));
      rdata = read_data;
      @(posedge clk);
      #1;
      cpu_read = 1'b0;
      cpu_write = 1'b0;
   endtask

   initial begin
      mem[32'h100] = {32'h44, 32'h33, 32'h22, 32'h11};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_stall", 128'(stall), 128'(0));
      chk("reset_mem_req", 128'(mem_req), 128'(0));
      chk("reset_read_data", 128'(read_data), 128'(0));
      lat = 3;
      access(1'b0, 2'b10, 32'h104, 32'h0);
      chk("miss_stall_cycles", 128'(stalls), 128'(4));
      chk("miss_refill_seen", 128'(saw_rf), 128'(1));
      chk("miss_mem_addr", 128'(rf_addr), 128'(32'h100));
      chk("miss_no_wb", 128'(saw_wb), 128'(0));
      chk("miss_read_data", 128'(rdata), 128'(32'h22));
      access(1'b1, 2'b00, 32'h101, 32'hAB);
      chk("sb_hit_stall", 128'(stalls), 128'(0));
      access(1'b0, 2'b10, 32'h100, 32'h0);
      chk("sb_read_back", 128'(rdata), 128'(32'h0000AB11));
      chk("sb_no_mem", 128'(saw_rf | saw_wb), 128'(0));
      access(1'b1, 2'b01, 32'h106, 32'h1234);
      access(1'b0, 2'b10, 32'h104, 32'h0);
      chk("half_upper", 128'(rdata), 128'(32'h12340022));
      access(1'b1, 2'b01, 32'h107, 32'hFFFF5678);
      access(1'b0, 2'b10, 32'h104, 32'h0);
      chk("half_a0_ignored", 128'(rdata), 128'(32'h56780022));
      access(1'b1, 2'b10, 32'h10B, 32'hCAFEF00D);
      access(1'b0, 2'b10, 32'h108, 32'h0);
      chk("word_low_bits_ignored", 128'(rdata), 128'(32'hCAFEF00D));
      access(1'b1, 2'b00, 32'h10F, 32'hFFFFFF7E);
      access(1'b0, 2'b10, 32'h10C, 32'h0);
      chk("byte_lane3", 128'(rdata), 128'(32'h7E000044));
      lat = 2;
      access(1'b0, 2'b10, 32'h000, 32'h0);
      access(1'b0, 2'b10, 32'h400, 32'h0);
      access(1'b0, 2'b10, 32'h800, 32'h0);
      access(1'b0, 2'b10, 32'hC00, 32'h0);
      access(1'b0, 2'b10, 32'h000, 32'h0);
      chk("touch_hit", 128'(stalls), 128'(0));
      lat = 1;
      access(1'b0, 2'b10, 32'h1000, 32'h0);
      chk("lru_stall", 128'(stalls), 128'(2));
      chk("lru_refill_addr", 128'(rf_addr), 128'(32'h1000));
      chk("lru_no_wb", 128'(saw_wb), 128'(0));
      access(1'b0, 2'b10, 32'h000, 32'h0);
      chk("lru_mru_kept", 128'(stalls), 128'(0));
      access(1'b0, 2'b10, 32'h800, 32'h0);
      chk("lru_800_kept", 128'(stalls), 128'(0));
      access(1'b1, 2'b10, 32'h400, 32'hDEADBEEF);
      chk("store_miss_stall", 128'(stalls), 128'(2));
      chk("store_miss_no_wb", 128'(saw_wb), 128'(0));
      lat = 2;
      access(1'b0, 2'b10, 32'h1400, 32'h0);
      access(1'b0, 2'b10, 32'h1800, 32'h0);
      access(1'b0, 2'b10, 32'h1C00, 32'h0);
      access(1'b0, 2'b10, 32'h2000, 32'h0);
      chk("dirty_wb_seen", 128'(saw_wb), 128'(1));
      chk("dirty_wb_addr", 128'(wb_addr), 128'(32'h400));
      chk("dirty_wb_lane0", 128'(wb_w0), 128'(32'hDEADBEEF));
      chk("dirty_refill_addr", 128'(rf_addr), 128'(32'h2000));
      chk("dirty_stall", 128'(stalls), 128'(5));
      access(1'b0, 2'b10, 32'h400, 32'h0);
      chk("wb_roundtrip", 128'(rdata), 128'(32'hDEADBEEF));
      chk("wb_roundtrip_clean", 128'(saw_wb), 128'(0));
      access(1'b1, 2'b10, 32'h104, 32'h0BADF00D);
      lat = 4;
      @(posedge clk);
      #1;
      cpu_read = 1'b1;
      cpu_size = 2'b10;
      cpu_addr = 32'h3000;
      @(posedge clk);
      #1;
      chk("refill_active", 128'(mem_req), 128'(1));
      rst = 1'b1;
      #1;
      chk("rst_drops_mem_req", 128'(mem_req), 128'(0));
      cpu_read = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      access(1'b0, 2'b10, 32'h104, 32'h0);
      chk("post_rst_miss_stall", 128'(stalls), 128'(5));
      chk("post_rst_refill_addr", 128'(rf_addr), 128'(32'h100));
      chk("post_rst_dirty_lost", 128'(rdata), 128'(32'h22));
      access(1'b0, 2'b10, 32'h100, 32'h0);
      chk("post_rst_hit", 128'(stalls), 128'(0));
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative write-back, write-allocate data cache between the CPU load/store unit and the block-wide main-memory port. It generalises the 2-way design to configurable ways, sets and line length. It uses true-LRU replacement, invalid-way-first allocation and byte/half/word stores. It stalls the CPU on misses and performs an optional dirty write-back followed by a line refill over a req/ready handshake.

## Interface
- `WIDTH`, 32, address/data width
- `WAYS`, 4, associativity, power of two, 2..8
- `SETS`, 64, sets per way, power of two
- `BLOCK_WORDS`, 4, 32-bit words per line, power of two
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `cpu_addr` in WIDTH: byte address
- `cpu_wdata` in 32: store data, right-aligned
- `cpu_read` in 1: load request
- `cpu_write` in 1: store request
- `cpu_size` in 2: 00 byte, 01 half, 10 word
- `read_data` out 32: full aligned word containing the addressed byte(s)
- `stall` out 1: CPU must hold its request
- `mem_req` out 1: memory transaction active
- `mem_we` out 1: 1 write-back, 0 refill
- `mem_addr` out WIDTH: line-aligned address
- `mem_wdata` out 32*BLOCK_WORDS: victim line
- `mem_rdata` in 32*BLOCK_WORDS: refill line
- `mem_ready` in 1: transaction complete this cycle

## Operation
- Address split: offset = 2+log2(BLOCK_WORDS) LSBs; index = next log2(SETS) bits; tag = remainder.
- Per line: valid, dirty, tag, data, and an LRU age of log2(WAYS) bits. Age 0 means most recent.
- Request = `cpu_read | cpu_write`. If both are high, the access is a store.
- Hit = some valid way in the indexed set has a matching tag. At most one way can match.
- Load hit: `read_data` = addressed word of the hit way. It is combinational. Otherwise `read_data` = 0.
- Store hit:
  - Byte: write lane `addr[1:0]`.
  - Half: write lanes `{addr[1],0}` and `{addr[1],1}`; `addr[0]` is ignored.
  - Word: write the full word; `addr[1:0]` is ignored.
  - The line's dirty bit is set.
- LRU update on every hit and every refill:
  - The accessed way's age becomes 0.
  - Ways whose age was below the old age increment by 1.
  - Ages within a set remain a permutation of 0..WAYS-1.
- Victim selection: the lowest-index invalid way. If all ways are valid, the way with age WAYS-1. The victim is latched at miss detection.
- FSM states:
  - IDLE: request && !hit goes to WRITE_BACK if the victim is valid and dirty, otherwise to REFILL.
  - WRITE_BACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 0}, `mem_wdata`=victim line. On `mem_ready`, go to REFILL.
  - REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, 0}. On `mem_ready`, install `mem_rdata` with valid=1, dirty=0 and new tag, update LRU, and go to IDLE.
- After a refill, the held request re-executes in IDLE as a hit, including applying the store.
- `stall` = (state != IDLE) | (request & !hit).
- `mem_addr` and `mem_wdata` are held constant while `mem_req`=1. `mem_ready` is ignored while `mem_req`=0.

## Timing
- Reset state:
  - FSM in IDLE.
  - All valid and dirty bits 0.
  - Ages of way w set to w.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- Reset mid-transaction aborts immediately. `mem_req` drops asynchronously and all lines are invalidated. Dirty data is lost by design.
- Hit: 0 wait cycles. A store commits at the next rising edge.
- Clean miss with memory latency L (`mem_ready` in the L-th REFILL cycle): `stall` is high for 1+L cycles. The hit is served in the following cycle.
- Dirty miss: `stall` is high for 1+Lwb+Lrf cycles.
- A request change while `stall`=1 is a protocol violation. Behaviour is undefined.

## Configuration
- `ASSOC_CACHE_STATS_EN` defined:
  - Adds outputs `hit_count`, `miss_count` and `wb_count`, each 32 bits, saturating, reset to 0.
  - `hit_count` increments on each IDLE cycle with request && hit. The post-refill retry counts as a hit.
  - `miss_count` increments on each IDLE->WRITE_BACK or IDLE->REFILL transition.
  - `wb_count` increments on each completed write-back.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
Default parameters apply: index is `addr[9:4]` and tag is `addr[31:10]`.

- Reset, then load 0x0000_0104 with memory returning line {0x44,0x33,0x22,0x11} after L=3 -> `stall` high for 4 cycles, `mem_addr`=0x100, `mem_we`=0, then `read_data`=0x22 with `stall` low.
- Store byte 0xAB to 0x0000_0101 on the resident line, then load 0x100 -> `read_data`=0x0000AB11, no `mem_req`.
- Fill set 0 with tags at 0x000, 0x400, 0x800 and 0xC00, touch 0x000, then load 0x1000 -> victim is way with 0x400, clean, no write-back, refill at 0x1000.
- Dirty eviction: store word 0xDEADBEEF to 0x400, then evict it -> WRITE_BACK with `mem_addr`=0x400 and lane 0 of `mem_wdata`=0xDEADBEEF, then REFILL.
- Assert `rst` during REFILL -> `mem_req` drops the same cycle; after release, a load of 0x100 misses again.
- With `ASSOC_CACHE_STATS_EN`, run the above sequence -> counters match the exact counts of hits, misses and write-backs.
